// File: rtl/serial_magnitude_comparator_if.sv
// Handshake/operand bundle for serial_magnitude_comparator.
// Cascade inputs gi/ei/li exist only when SERIAL_CMP_CASCADE_IN_EN is defined.
interface serial_magnitude_comparator_if #(
  parameter int NIBBLES = 4
);
  logic                   start;
  logic [4*NIBBLES-1:0]   a_in;
  logic [4*NIBBLES-1:0]   b_in;
`ifdef SERIAL_CMP_CASCADE_IN_EN
  logic                   gi;
  logic                   ei;
  logic                   li;
`endif
  logic                   busy;
  logic                   done;
  logic                   gt;
  logic                   eq;
  logic                   lt;

  modport master (
    output start, a_in, b_in,
`ifdef SERIAL_CMP_CASCADE_IN_EN
    output gi, ei, li,
`endif
    input  busy, done, gt, eq, lt
  );

  modport slave (
    input  start, a_in, b_in,
`ifdef SERIAL_CMP_CASCADE_IN_EN
    input  gi, ei, li,
`endif
    output busy, done, gt, eq, lt
  );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Nibble-serial unsigned magnitude comparator: one 4-bit cascade compare per clock, LSB nibble first.
// Optional macro SERIAL_CMP_CASCADE_IN_EN adds gi/ei/li as the initial cascade flags.
module serial_magnitude_comparator #(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  serial_magnitude_comparator_if.slave  bus
);
  localparam int W     = 4 * NIBBLES;
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [CNT_W-1:0] r_cnt;
  logic             r_g, r_e, r_l;
  logic             r_busy, r_done;
  logic             r_gt, r_eq, r_lt;

  logic             w_accept;
  logic [3:0]       w_a_nib, w_b_nib;
  logic             w_g, w_e, w_l;
  logic             w_gi, w_ei, w_li;

`ifdef SERIAL_CMP_CASCADE_IN_EN
  assign w_gi = bus.gi;
  assign w_ei = bus.ei;
  assign w_li = bus.li;
`else
  assign w_gi = 1'b0;
  assign w_ei = 1'b1;
  assign w_li = 1'b0;
`endif

  assign w_accept = bus.start && ((r_state == IDLE) || (r_state == DONE));

  // Operands shift down each RUN cycle so the current nibble is always at [3:0].
  assign w_a_nib = r_a[3:0];
  assign w_b_nib = r_b[3:0];

  always_comb begin
    w_g = r_g;
    w_e = r_e;
    w_l = r_l;
    if (w_a_nib > w_b_nib) begin
      w_g = 1'b1;
      w_e = 1'b0;
      w_l = 1'b0;
    end else if (w_a_nib < w_b_nib) begin
      w_g = 1'b0;
      w_e = 1'b0;
      w_l = 1'b1;
    end
  end

  // Operand datapath carries no reset; it is always reloaded by an accepted start.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= bus.a_in;
      r_b <= bus.b_in;
    end else if (r_state == RUN) begin
      r_a <= r_a >> 4;
      r_b <= r_b >> 4;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_g     <= 1'b0;
      r_e     <= 1'b1;
      r_l     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_gt    <= 1'b0;
      r_eq    <= 1'b1;
      r_lt    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_g     <= w_gi;
            r_e     <= w_ei;
            r_l     <= w_li;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_g   <= w_g;
          r_e   <= w_e;
          r_l   <= w_l;
          r_cnt <= r_cnt + 1'b1;
          // Final nibble: publish the cascade result including this nibble's decision.
          if (r_cnt == LAST_CNT) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_gt    <= w_g;
            r_eq    <= w_e;
            r_lt    <= w_l;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.gt   = r_gt;
  assign bus.eq   = r_eq;
  assign bus.lt   = r_lt;
endmodule
